// File: rtl/hazard3_muldiv_issue_pkg.sv
// Shared op encodings and decode helpers for the mul/div issue stage and its result cache.
// The key groups ops that the sequential unit computes identically, so either half can be reused.
package hazard3_muldiv_issue_pkg;

  localparam int W_MULOP = 3;

  localparam logic [W_MULOP-1:0] M_OP_MUL    = 3'd0;
  localparam logic [W_MULOP-1:0] M_OP_MULH   = 3'd1;
  localparam logic [W_MULOP-1:0] M_OP_MULHSU = 3'd2;
  localparam logic [W_MULOP-1:0] M_OP_MULHU  = 3'd3;
  localparam logic [W_MULOP-1:0] M_OP_DIV    = 3'd4;
  localparam logic [W_MULOP-1:0] M_OP_DIVU   = 3'd5;
  localparam logic [W_MULOP-1:0] M_OP_REM    = 3'd6;
  localparam logic [W_MULOP-1:0] M_OP_REMU   = 3'd7;

  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
  } md_key_t;

  function automatic md_key_t md_op_key(input logic [W_MULOP-1:0] op);
    md_key_t k;
    k = '0;
    case (op)
      M_OP_MULH:           k = {1'b0, 1'b1, 1'b1};
      M_OP_MULHSU:         k = {1'b0, 1'b1, 1'b0};
      M_OP_DIV,  M_OP_REM: k = {1'b1, 1'b1, 1'b1};
      M_OP_DIVU, M_OP_REMU: k = {1'b1, 1'b0, 1'b0};
      default:             k = '0;
    endcase
    return k;
  endfunction

  // Low half carries the product low word or the quotient; everything else wants the high half.
  function automatic logic md_takes_low(input logic [W_MULOP-1:0] op);
    return (op == M_OP_MUL) || (op == M_OP_DIV) || (op == M_OP_DIVU);
  endfunction

endpackage

// File: rtl/hazard3_muldiv_rcache.sv
// One-entry result cache: the operand values plus op key form the tag, so entries never go stale.
// A MUL lookup also hits any multiply entry, since the low product word is signedness-independent.
module hazard3_muldiv_rcache
  import hazard3_muldiv_issue_pkg::*;
#(
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  md_key_t           lookup_key_i,
  input  logic              lookup_is_mul_i,
  input  logic [W_DATA-1:0] lookup_a_i,
  input  logic [W_DATA-1:0] lookup_b_i,
  output logic              hit_o,
  output logic [W_DATA-1:0] hit_h_o,
  output logic [W_DATA-1:0] hit_l_o,
  input  logic              fill_i,
  input  md_key_t           fill_key_i,
  input  logic [W_DATA-1:0] fill_a_i,
  input  logic [W_DATA-1:0] fill_b_i,
  input  logic [W_DATA-1:0] fill_h_i,
  input  logic [W_DATA-1:0] fill_l_i
);

  logic              vld_q;
  md_key_t           key_q;
  logic [W_DATA-1:0] a_q, b_q, h_q, l_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      key_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      h_q   <= '0;
      l_q   <= '0;
    end else if (fill_i) begin
      vld_q <= 1'b1;
      key_q <= fill_key_i;
      a_q   <= fill_a_i;
      b_q   <= fill_b_i;
      h_q   <= fill_h_i;
      l_q   <= fill_l_i;
    end
  end

  assign hit_o = vld_q && (a_q == lookup_a_i) && (b_q == lookup_b_i) &&
                 ((key_q == lookup_key_i) || (lookup_is_mul_i && !key_q.is_div));
  assign hit_h_o = h_q;
  assign hit_l_o = l_q;

endmodule

// File: rtl/hazard3_muldiv_issue.sv
// Issue/response stage in front of the sequential mul/div unit, with an optional result cache.
// Handshake: a transfer happens on any cycle where vld && rdy are both high on req_* or rsp_*.
module hazard3_muldiv_issue
  import hazard3_muldiv_issue_pkg::*;
#(
  parameter int W_DATA       = 32,
  parameter int RESULT_CACHE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [W_MULOP-1:0] req_op,
  input  logic [W_DATA-1:0]  req_a,
  input  logic [W_DATA-1:0]  req_b,
  input  logic               req_kill,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [W_DATA-1:0]  rsp_data,
  output logic [W_MULOP-1:0] md_op,
  output logic               md_op_vld,
  input  logic               md_op_rdy,
  output logic               md_op_kill,
  output logic [W_DATA-1:0]  md_op_a,
  output logic [W_DATA-1:0]  md_op_b,
  input  logic [W_DATA-1:0]  md_result_h,
  input  logic [W_DATA-1:0]  md_result_l,
  input  logic               md_result_vld,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W_MULOP-1:0] op_q, op_d;
  logic [W_DATA-1:0]  a_q, a_d, b_q, b_d;
  logic [W_DATA-1:0]  rsp_data_q, rsp_data_d;
  logic               first_q, first_d;
  logic               hit, fill;
  logic [W_DATA-1:0]  hit_h, hit_l;

  generate
    if (RESULT_CACHE != 0) begin : g_cache
      hazard3_muldiv_rcache #(.W_DATA(W_DATA)) u_rcache (
        .clk             (clk),
        .rst_n           (rst_n),
        .lookup_key_i    (md_op_key(req_op)),
        .lookup_is_mul_i (req_op == M_OP_MUL),
        .lookup_a_i      (req_a),
        .lookup_b_i      (req_b),
        .hit_o           (hit),
        .hit_h_o         (hit_h),
        .hit_l_o         (hit_l),
        .fill_i          (fill),
        .fill_key_i      (md_op_key(op_q)),
        .fill_a_i        (a_q),
        .fill_b_i        (b_q),
        .fill_h_i        (md_result_h),
        .fill_l_i        (md_result_l)
      );
    end else begin : g_nocache
      assign hit   = 1'b0;
      assign hit_h = '0;
      assign hit_l = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      first_q    <= first_d;
    end
  end

  assign req_rdy = (state_q == S_IDLE) && md_op_rdy && !req_kill;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    first_d    = 1'b0;
    md_op_vld  = 1'b0;
    md_op_kill = 1'b0;
    fill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_vld && req_rdy) begin
          if (hit) begin
            rsp_data_d = md_takes_low(req_op) ? hit_l : hit_h;
            state_d    = S_RESP;
          end else begin
            md_op_vld = 1'b1;
            op_d      = req_op;
            a_d       = req_a;
            b_d       = req_b;
            first_d   = 1'b1;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // The unit still shows the previous op's result during the first busy cycle.
        if (req_kill) begin
          md_op_kill = 1'b1;
          state_d    = S_IDLE;
        end else if (md_result_vld && !first_q) begin
          rsp_data_d = md_takes_low(op_q) ? md_result_l : md_result_h;
          fill       = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (req_kill || rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_vld     = (state_q == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign md_op       = req_op;
  assign md_op_a     = req_a;
  assign md_op_b     = req_b;
  assign dbg_state_o = state_q;

endmodule
